mesh_term_arbiter: RTL and testbench
====================================

Name: mesh_term_arbiter

Overview:
- Shares one mesh terminal input port (pndng/data/pop handshake) among NUM_REQ local requesters, e.g. several agent FIFOs feeding one router terminal.
- Selects a winner by round-robin or fixed priority and captures its packet into a single output holding register.
- Presents the held packet to the router until the router pops it.
- Sits between the terminal-side sources and the router's data_out_i_in/pndng_i_in/pop terminal port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- PCKG_SZ, 32, packet width in bits
- TIMEOUT, 64, cycles in HOLD before err_timeout is flagged; 0 disables the check
- CNT_W, 16, width of the delivered-packet counter

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- req_pndng  input  NUM_REQ  requester i has a packet pending
- req_data  input  NUM_REQ*PCKG_SZ  flattened; slice i = requester i packet
- req_pop  output  NUM_REQ  one-cycle pulse; requester i's packet has been captured
- term_pndng  output  1  packet valid toward router (drives pndng_i_in)
- term_data  output  PCKG_SZ  held packet (drives data_out_i_in)
- term_pop  input  1  router consumed term_data (from pop)
- rr_en  input  1  1 = round-robin, 0 = fixed priority (lowest index wins)
- err_clr  input  1  clears err_timeout
- busy  output  1  high while in HOLD
- grant_id  output  $clog2(NUM_REQ)  index of the last captured requester
- err_timeout  output  1  sticky: HOLD lasted at least TIMEOUT cycles
- pkt_cnt  output  CNT_W  packets delivered (term_pop accepted); wraps

Behaviour:
- Reset values: req_pop=0, term_pndng=0, term_data=0, busy=0, grant_id=0, err_timeout=0, pkt_cnt=0, state=IDLE, rr_ptr=NUM_REQ-1.
- Reset takes effect on the next edge. A packet held mid-operation is dropped, and term_pndng is 0 from the next cycle.

FSM:
- IDLE, no req_pndng set: stay in IDLE.
- IDLE, any req_pndng set:
  - Combinationally pick winner w; assert req_pop[w] in the same cycle.
  - On the edge: term_data <= req_data[w], grant_id <= w, rr_ptr <= w, term_pndng <= 1, go to HOLD.
- Latency: request seen in IDLE gives term_pndng=1 on the next cycle.
- HOLD:
  - term_pndng=1; term_data and grant_id stay stable.
  - No req_pop is asserted.
  - On term_pop: term_pndng <= 0, pkt_cnt <= pkt_cnt+1 (mod 2^CNT_W), go to IDLE.
- After a pop, term_pndng is low for at least one cycle. No back-to-back delivery: maximum throughput is 1 packet per 2 cycles.
- term_pop while in IDLE is ignored; it does not touch the counter.

Selection:
- Round-robin: scan indices rr_ptr+1 .. rr_ptr+NUM_REQ, taken mod NUM_REQ; the first set req_pndng wins.
- Fixed priority: the lowest set index wins.
- rr_ptr updates to the winner in both modes.
- Changing rr_en takes effect on the next arbitration.
- Requesters must hold req_data stable while req_pndng=1 until popped. The arbiter only pops when req_pndng[w]=1.

Timeout:
- hold_cnt clears on entry to HOLD and increments each HOLD cycle, saturating at TIMEOUT.
- When hold_cnt reaches TIMEOUT (TIMEOUT≠0), err_timeout <= 1. The packet keeps being held; timeout never drops data.
- err_clr clears err_timeout. If set and clear occur in the same cycle, set wins.

Decomposition:
- Package mesh_arb_pkg: arb_state_e {IDLE, HOLD}; function idx_w(n) returning $clog2 with a minimum of 1.
- Sub-module mesh_rr_pick: combinational.
  - Inputs: req vector, rr_ptr, rr_en.
  - Outputs: any_req, winner index.
- The top level holds the FSM, output register, timeout counter and pkt_cnt.

Test Plan:
- Single request: req_pndng=4'b0100, req_data[2]=32'hDEAD_BEEF.
  - req_pop[2] pulses exactly 1 cycle.
  - Next cycle: term_pndng=1, term_data=DEADBEEF, grant_id=2.
  - term_pop 3 cycles later: term_pndng=0 next cycle, pkt_cnt=1.
- Round-robin fairness: rr_en=1, all 4 requesting continuously, router pops every HOLD cycle.
  - Grant order 0,1,2,3,0,1.
  - Exactly one pulse per requester per 8 cycles.
- Fixed priority: rr_en=0, req_pndng=4'b1010 held.
  - Every grant is to 1.
  - Switch to rr_en=1 after grant 1: next grant is 3.
- Stall and timeout: TIMEOUT=8, term_pop held low for 20 cycles.
  - err_timeout rises once hold_cnt reaches 8; term_data stays stable throughout.
  - term_pop then delivers the packet.
  - err_clr clears err_timeout, except in a cycle where a new set coincides (set wins).
- Reset mid-HOLD: assert reset while term_pndng=1.
  - Next cycle: term_pndng=0, pkt_cnt=0, err_timeout=0.
  - First grant after reset is requester 0 when all are requesting.
- Protocol checks bound for all runs:
  - req_pop[i] implies req_pndng[i].
  - term_data is stable while term_pndng && !term_pop.
  - term_pop implies term_pndng is 0 in the next cycle.
  - At most one req_pop bit set per cycle.

Source files
------------

// File: rtl/mesh_arb_pkg.sv
// Shared types and helpers for the mesh terminal arbiter.
// Contents:
//   arb_state_e : arbiter FSM states (IDLE waits for a request, HOLD presents
//                 the captured packet to the router)
//   idx_w(n)    : bits needed to index n items, never less than 1
package mesh_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // A bare $clog2 returns 0 for n <= 1. That would give zero-width vectors,
  // so the result is clamped to at least one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mesh_rr_pick.sv
// Combinational winner selection for the mesh terminal arbiter.
// Ports:
//   i_req     : pending-request vector, one bit per requester
//   i_rr_ptr  : index of the previous winner; the round-robin scan starts
//               just after it
//   i_rr_en   : 1 = round-robin, 0 = fixed priority (lowest index wins)
//   o_any_req : at least one request is pending
//   o_winner  : selected requester index (0 when nothing is pending)
module mesh_rr_pick
  import mesh_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_rr_ptr,
  input  logic               i_rr_en,
  output logic               o_any_req,
  output logic [IW-1:0]      o_winner
);

  logic w_found;
  int   w_idx;

  assign o_any_req = |i_req;

  // Round-robin walks the indices after the previous winner, wrapping
  // around, and keeps the first pending one. Fixed priority scans downward
  // so that the lowest pending index is the one that sticks.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    if (i_rr_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
        if (!w_found && i_req[w_idx]) begin
          o_winner = IW'(w_idx);
          w_found  = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_winner = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mesh_term_arbiter.sv
// Shares one mesh router terminal input (pndng/data/pop) among NUM_REQ
// local requesters. A winner is captured into a single holding register and
// presented to the router until the router pops it.
// Ports:
//   clk, reset   : clock; synchronous active-high reset
//   req_pndng    : requester i has a packet pending
//   req_data     : flattened packets; slice i belongs to requester i
//   req_pop      : one-cycle pulse; requester i's packet was captured
//   term_pndng   : held packet is valid toward the router
//   term_data    : held packet
//   term_pop     : router consumed term_data
//   rr_en        : 1 = round-robin, 0 = fixed priority
//   err_clr      : clears err_timeout
//   busy         : high while a packet is being held
//   grant_id     : index of the last captured requester
//   err_timeout  : sticky; a hold lasted at least TIMEOUT cycles
//   pkt_cnt      : packets delivered to the router (wraps)
module mesh_term_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PCKG_SZ = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_pndng,
  input  logic [NUM_REQ*PCKG_SZ-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_pop,
  output logic                       term_pndng,
  output logic [PCKG_SZ-1:0]         term_data,
  input  logic                       term_pop,
  input  logic                       rr_en,
  input  logic                       err_clr,
  output logic                       busy,
  output logic [idx_w(NUM_REQ)-1:0]  grant_id,
  output logic                       err_timeout,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int HW = idx_w(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = (TIMEOUT == 0) ? '0 : HW'(TIMEOUT - 1);

  arb_state_e         r_state;
  logic               r_term_pndng;
  logic [PCKG_SZ-1:0] r_term_data;
  logic [IW-1:0]      r_grant_id;
  logic [IW-1:0]      r_rr_ptr;
  logic [HW-1:0]      r_hold_cnt;
  logic               r_err_timeout;
  logic [CNT_W-1:0]   r_pkt_cnt;

  logic               w_any_req;
  logic [IW-1:0]      w_winner;
  logic [PCKG_SZ-1:0] w_req_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_req_pop;
  logic               w_to_hit;

  // View the flattened data bus as an array indexed by requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_arr[g] = req_data[g*PCKG_SZ +: PCKG_SZ];
  end

  mesh_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req     (req_pndng),
    .i_rr_ptr  (r_rr_ptr),
    .i_rr_en   (rr_en),
    .o_any_req (w_any_req),
    .o_winner  (w_winner)
  );

  // The pop pulse has to appear in the same cycle as the capture decision,
  // so it is decoded combinationally. It is suppressed under reset: the
  // capture is discarded on that edge, and popping anyway would lose the
  // requester's packet.
  always_comb begin
    w_req_pop = '0;
    if ((r_state == IDLE) && w_any_req && !reset) begin
      w_req_pop[w_winner] = 1'b1;
    end
  end

  // The timeout fires on the edge where the hold counter steps onto
  // TIMEOUT. Once the counter saturates this is no longer true, so err_clr
  // can clear the flag during a stall that continues.
  assign w_to_hit = (TIMEOUT != 0) && (r_state == HOLD) && (r_hold_cnt == HOLD_LAST);

  // Main FSM. IDLE captures the winner into the holding register. HOLD
  // presents it until the router pops it, and then always returns through
  // IDLE, so term_pndng drops for at least one cycle between packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_term_pndng  <= 1'b0;
      r_term_data   <= '0;
      r_grant_id    <= '0;
      r_rr_ptr      <= IW'(NUM_REQ - 1);
      r_hold_cnt    <= '0;
      r_err_timeout <= 1'b0;
      r_pkt_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_term_data  <= w_req_arr[w_winner];
            r_grant_id   <= w_winner;
            r_rr_ptr     <= w_winner;
            r_term_pndng <= 1'b1;
            r_hold_cnt   <= '0;
            r_state      <= HOLD;
          end
          if (err_clr) begin
            r_err_timeout <= 1'b0;
          end
        end
        HOLD: begin
          if (r_hold_cnt != HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
          if (w_to_hit) begin
            r_err_timeout <= 1'b1;
          end else if (err_clr) begin
            r_err_timeout <= 1'b0;
          end
          if (term_pop) begin
            r_term_pndng <= 1'b0;
            r_pkt_cnt    <= r_pkt_cnt + CNT_W'(1);
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_pop     = w_req_pop;
  assign term_pndng  = r_term_pndng;
  assign term_data   = r_term_data;
  assign busy        = (r_state == HOLD);
  assign grant_id    = r_grant_id;
  assign err_timeout = r_err_timeout;
  assign pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_mesh_term_arbiter.sv
// Self-checking bench for mesh_term_arbiter (4 requesters, TIMEOUT = 8).
// A behavioural model of the arbiter runs alongside the DUT every cycle.
// On top of it sit a table of hand-derived vectors, hand-written corner
// sequences, and a randomized traffic phase.
module tb_mesh_term_arbiter;

  localparam int NR = 4;
  localparam int PW = 32;
  localparam int TO = 8;
  localparam int CW = 16;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   reqPndng;
  logic [NR*PW-1:0] reqDataBus;
  logic [NR-1:0]   reqPop;
  logic            termPndng;
  logic [PW-1:0]   termData;
  logic            termPop;
  logic            rrEn;
  logic            errClr;
  logic            busyOut;
  logic [1:0]      grantId;
  logic            errTimeout;
  logic [CW-1:0]   pktCnt;

  logic [PW-1:0]   reqData [NR];

  int vecCount  = 0;
  int missCount = 0;

  // Behavioural model state
  bit              mHold;
  logic [PW-1:0]   mData;
  int              mGid;
  int              mLast;
  int              mHeld;
  bit              mErr;
  logic [CW-1:0]   mCnt;
  logic [NR-1:0]   mPopExp;

  typedef struct {
    logic          rst;
    logic [NR-1:0] pnd;
    logic          rr;
    logic          tpop;
    logic          eclr;
    logic [NR-1:0] ePop;
    logic          eTp;
    logic [1:0]    eGid;
    logic [PW-1:0] eData;
    logic [CW-1:0] eCnt;
  } vec_t;

  vec_t vecs [16];

  mesh_term_arbiter #(
    .NUM_REQ (NR),
    .PCKG_SZ (PW),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .req_pndng   (reqPndng),
    .req_data    (reqDataBus),
    .req_pop     (reqPop),
    .term_pndng  (termPndng),
    .term_data   (termData),
    .term_pop    (termPop),
    .rr_en       (rrEn),
    .err_clr     (errClr),
    .busy        (busyOut),
    .grant_id    (grantId),
    .err_timeout (errTimeout),
    .pkt_cnt     (pktCnt)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the flow
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NR-1:0] p, input logic rr,
                               input logic tp, input logic ec);
    rst      = r;
    reqPndng = p;
    rrEn     = rr;
    termPop  = tp;
    errClr   = ec;
    for (int i = 0; i < NR; i++) reqDataBus[i*PW +: PW] = reqData[i];
  endtask

  function automatic void modelReset();
    mHold   = 0;
    mData   = '0;
    mGid    = 0;
    mLast   = NR - 1;
    mHeld   = 0;
    mErr    = 0;
    mCnt    = '0;
    mPopExp = '0;
  endfunction

  // Winner = pending requester at the smallest rotational distance after
  // the last winner (round-robin) or the lowest pending index (fixed).
  function automatic int pickWinner();
    int best;
    int bestDist;
    best     = -1;
    bestDist = NR;
    for (int i = 0; i < NR; i++) begin
      if (reqPndng[i]) begin
        int d;
        d = rrEn ? ((i - mLast - 1 + 2*NR) % NR) : i;
        if (d < bestDist) begin
          bestDist = d;
          best     = i;
        end
      end
    end
    return best;
  endfunction

  // Compares the DUT against the model at the negative edge, then advances
  // the model by the upcoming clock edge.
  task automatic modelStep();
    logic [NR-1:0] expPop;
    int w;
    expPop = '0;
    checkOutput("term_pndng", 64'(termPndng), 64'(mHold));
    checkOutput("busy", 64'(busyOut), 64'(mHold));
    if (mHold) checkOutput("term_data", 64'(termData), 64'(mData));
    checkOutput("grant_id", 64'(grantId), 64'(mGid));
    checkOutput("err_timeout", 64'(errTimeout), 64'(mErr));
    checkOutput("pkt_cnt", 64'(pktCnt), 64'(mCnt));
    if (rst) begin
      modelReset();
    end else if (!mHold) begin
      w = pickWinner();
      if (w >= 0) begin
        expPop[w] = 1'b1;
        mHold = 1;
        mData = reqDataBus[w*PW +: PW];
        mGid  = w;
        mLast = w;
        mHeld = 0;
      end
      if (errClr) mErr = 0;
    end else begin
      mHeld++;
      if (TO != 0 && mHeld == TO) mErr = 1;
      else if (errClr) mErr = 0;
      if (termPop) begin
        mHold = 0;
        mCnt  = mCnt + 1'b1;
      end
    end
    checkOutput("req_pop", 64'(reqPop), 64'(expPop));
    mPopExp = expPop;
  endtask

  task automatic atNeg();
    @(negedge clk);
  endtask

  task automatic finishCycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic plainCycle(input logic r, input logic [NR-1:0] p, input logic rr,
                            input logic tp, input logic ec);
    applyStimulus(r, p, rr, tp, ec);
    atNeg();
    finishCycle();
  endtask

  // Main test sequence
  initial begin
    logic [NR-1:0] srcPend;
    logic rrR, tpR, ecR, rstR;
    int grants[$];
    int winCount [NR];
    int expOrder [6];
    logic [PW-1:0] stallData;

    for (int i = 0; i < NR; i++) reqData[i] = 32'hA5A5_0000 + i;
    reqData[2] = 32'hDEAD_BEEF;

    // Hand-derived vectors: single request, IDLE pop ignored, fixed
    // priority, then a switch to round-robin.
    vecs[0]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 32'h0,         16'd0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hDEAD_BEEF, 16'd0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hDEAD_BEEF, 16'd0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hDEAD_BEEF, 16'd0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h0,         16'd1};
    vecs[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h0,         16'd1};
    vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h0,         16'd1};
    vecs[7]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd2, 32'h0,         16'd1};
    vecs[8]  = '{1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA5A5_0001, 16'd1};
    vecs[9]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd1, 32'h0,         16'd2};
    vecs[10] = '{1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA5A5_0001, 16'd2};
    vecs[11] = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd1, 32'h0,         16'd3};
    vecs[12] = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hA5A5_0003, 16'd3};
    vecs[13] = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd3, 32'h0,         16'd4};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA5A5_0001, 16'd4};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 32'h0,         16'd5};

    // Initial reset; DUT state is unknown before the first edge.
    applyStimulus(1'b1, '0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    modelReset();
    plainCycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    atNeg();
    checkOutput("pop_in_reset", 64'(reqPop), 64'(0));
    finishCycle();

    // Table-driven vectors
    for (int v = 0; v < 16; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].pnd, vecs[v].rr, vecs[v].tpop, vecs[v].eclr);
      atNeg();
      checkOutput($sformatf("vec%0d_pop", v), 64'(reqPop), 64'(vecs[v].ePop));
      checkOutput($sformatf("vec%0d_pndng", v), 64'(termPndng), 64'(vecs[v].eTp));
      checkOutput($sformatf("vec%0d_gid", v), 64'(grantId), 64'(vecs[v].eGid));
      checkOutput($sformatf("vec%0d_cnt", v), 64'(pktCnt), 64'(vecs[v].eCnt));
      if (vecs[v].eTp) checkOutput($sformatf("vec%0d_data", v), 64'(termData), 64'(vecs[v].eData));
      finishCycle();
    end

    // Stall: hold for 20 cycles, timeout rises after 8 hold cycles, err_clr
    // clears it once saturated, then the packet is delivered.
    plainCycle(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    stallData = reqData[0];
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, (k == 12));
      atNeg();
      checkOutput("stall_data", 64'(termData), 64'(stallData));
      checkOutput("stall_pndng", 64'(termPndng), 64'(1));
      if (k == 7)  checkOutput("err_before_limit", 64'(errTimeout), 64'(0));
      if (k == 8)  checkOutput("err_rise", 64'(errTimeout), 64'(1));
      if (k == 13) checkOutput("err_cleared", 64'(errTimeout), 64'(0));
      finishCycle();
    end
    plainCycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    atNeg();
    checkOutput("stall_delivered_pndng", 64'(termPndng), 64'(0));
    checkOutput("stall_delivered_cnt", 64'(pktCnt), 64'(6));
    finishCycle();

    // Set and clear in the same cycle: set wins.
    plainCycle(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, (k <= 7));
      atNeg();
      if (k == 8) checkOutput("set_wins_err", 64'(errTimeout), 64'(1));
      finishCycle();
    end

    // Reset while a packet is held, then all four request continuously
    // with the router popping at once.
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    atNeg();
    checkOutput("pndng_before_reset", 64'(termPndng), 64'(1));
    finishCycle();
    for (int i = 0; i < NR; i++) winCount[i] = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
      atNeg();
      if (k == 0) begin
        checkOutput("rst_pndng", 64'(termPndng), 64'(0));
        checkOutput("rst_cnt", 64'(pktCnt), 64'(0));
        checkOutput("rst_err", 64'(errTimeout), 64'(0));
      end
      for (int i = 0; i < NR; i++) begin
        if (reqPop[i]) begin
          grants.push_back(i);
          if (k < 8) winCount[i]++;
        end
      end
      finishCycle();
    end
    expOrder = '{0, 1, 2, 3, 0, 1};
    checkOutput("rr_grant_count", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) checkOutput($sformatf("rr_order%0d", i), 64'(grants[i]), 64'(expOrder[i]));
    end
    for (int i = 0; i < NR; i++) checkOutput($sformatf("rr_fair%0d", i), 64'(winCount[i]), 64'(1));

    // Randomized traffic against the model, with periodic long stalls
    srcPend = '0;
    rrR = 1'b1;
    for (int n = 0; n < 800; n++) begin
      rstR = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 19) == 0) rrR = ~rrR;
      tpR = ((n % 100) < 20) ? 1'b0 : ($urandom_range(0, 9) < 6);
      ecR = ($urandom_range(0, 9) == 0);
      applyStimulus(rstR, srcPend, rrR, tpR, ecR);
      atNeg();
      if (reqPop & (reqPop - 1'b1)) begin
        checkOutput("pop_onehot", 64'(reqPop), 64'(0));
      end
      finishCycle();
      for (int i = 0; i < NR; i++) begin
        if (mPopExp[i]) srcPend[i] = 1'b0;
        if (!srcPend[i] && $urandom_range(0, 2) == 0) begin
          srcPend[i] = 1'b1;
          reqData[i] = $urandom;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
